// File: rtl/cont_pkg.sv
// Shared FSM encoding and default parameter values for the run/pause/step counter sequencer.
// Pure declarations: no logic, no latency, no flow control.
package cont_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam int PRESCALE_DEF = 50_000_000;
   localparam int DEBOUNCE_DEF = 500_000;
   localparam int MOD_DEF      = 8;
   localparam int W_DEF        = 3;

endpackage

// File: rtl/cont_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level debounce, one-cycle press pulse on accepted 1->0.
// Latency 2 + DEBOUNCE_CYC cycles from pin to pulse; no backpressure, the pulse is never held.
module cont_debounce
   import cont_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press_p
);

   localparam int CW = $clog2(DEBOUNCE_CYC);

   logic          sync0_q, sync1_q;
   logic          lvl_q, lvl_d;
   logic          armed_q, armed_d;
   logic          press_q, press_d;
   logic [1:0]    settle_q, settle_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      lvl_d    = lvl_q;
      cnt_d    = '0;
      settle_d = {settle_q[0], 1'b1};
      if (sync1_q != lvl_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
            lvl_d = sync1_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      // Arm only after a genuine released sample, so a button held through reset never fires.
      armed_d = armed_q | (settle_q[1] & lvl_q & sync1_q);
      press_d = armed_q & lvl_q & ~lvl_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0_q  <= 1'b1;
         sync1_q  <= 1'b1;
         lvl_q    <= 1'b1;
         armed_q  <= 1'b0;
         press_q  <= 1'b0;
         settle_q <= 2'b00;
         cnt_q    <= '0;
      end else begin
         sync0_q  <= btn_n;
         sync1_q  <= sync0_q;
         lvl_q    <= lvl_d;
         armed_q  <= armed_d;
         press_q  <= press_d;
         settle_q <= settle_d;
         cnt_q    <= cnt_d;
      end
   end

   assign press_p = press_q;

endmodule

// File: rtl/cont_ctrl.sv
// Run/pause/step sequencer owning the modulo count for the HEX4 decoder; CONT_CTRL_AUTORUN_EN adds the prescaled auto-advance.
// Outputs registered one cycle after a command pulse or tick; no backpressure, commands are never queued.
module cont_ctrl
   import cont_pkg::*;
#(
   parameter int PRESCALE     = PRESCALE_DEF,
   parameter int DEBOUNCE_CYC = DEBOUNCE_DEF,
   parameter int MOD          = MOD_DEF,
   parameter int W            = W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         btn_run_n,
   input  logic         btn_step_n,
   input  logic         up_dn,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         running,
   output logic         tc
);

   if ((PRESCALE < 2) || (DEBOUNCE_CYC < 2) || (MOD < 2) || (MOD > 2**W)) begin : g_bad_cfg
      $error("cont_ctrl: parameter out of range");
   end

   logic         run_p, step_p;
   logic         dir0_q, dir1_q;
   state_t       state_q, state_d;
   logic [W-1:0] count_q, count_d;
   logic         running_q, running_d;
   logic         tc_q, tc_d;
   logic         adv;
`ifdef CONT_CTRL_AUTORUN_EN
   localparam int PW = $clog2(PRESCALE);
   logic [PW-1:0] presc_q, presc_d;
   logic          tick;
`endif

   cont_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_run_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_n   (btn_run_n),
      .press_p (run_p)
   );

   cont_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_n   (btn_step_n),
      .press_p (step_p)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
      adv     = 1'b0;
`ifdef CONT_CTRL_AUTORUN_EN
      presc_d = presc_q;
      tick    = (presc_q == PW'(PRESCALE - 1));
`endif
      // run_p is tested first everywhere so a simultaneous step is dropped.
      case (state_q)
         ST_IDLE: begin
            count_d = '0;
            if (run_p) begin
               state_d = ST_RUN;
`ifdef CONT_CTRL_AUTORUN_EN
               presc_d = '0;
`endif
            end else if (step_p) begin
               state_d = ST_PAUSE;
               adv     = 1'b1;
            end
         end
         ST_RUN: begin
            if (run_p) begin
               state_d = ST_PAUSE;
            end else begin
`ifdef CONT_CTRL_AUTORUN_EN
               presc_d = tick ? '0 : presc_q + 1'b1;
               adv     = tick;
`else
               adv     = step_p;
`endif
            end
         end
         ST_PAUSE: begin
            if (run_p) begin
               state_d = ST_RUN;
`ifdef CONT_CTRL_AUTORUN_EN
               presc_d = '0;
`endif
            end else begin
               adv = step_p;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (adv) begin
         if (dir1_q) begin
            if (count_q == W'(MOD - 1)) begin
               count_d = '0;
               tc_d    = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end else begin
            if (count_q == '0) begin
               count_d = W'(MOD - 1);
               tc_d    = 1'b1;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end

      if (clr) begin
         state_d = ST_IDLE;
         count_d = '0;
         tc_d    = 1'b0;
`ifdef CONT_CTRL_AUTORUN_EN
         presc_d = '0;
`endif
      end

      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir0_q    <= 1'b1;
         dir1_q    <= 1'b1;
         state_q   <= ST_IDLE;
         count_q   <= '0;
         running_q <= 1'b0;
         tc_q      <= 1'b0;
`ifdef CONT_CTRL_AUTORUN_EN
         presc_q   <= '0;
`endif
      end else begin
         dir0_q    <= up_dn;
         dir1_q    <= dir0_q;
         state_q   <= state_d;
         count_q   <= count_d;
         running_q <= running_d;
         tc_q      <= tc_d;
`ifdef CONT_CTRL_AUTORUN_EN
         presc_q   <= presc_d;
`endif
      end
   end

   assign count   = count_q;
   assign running = running_q;
   assign tc      = tc_q;

endmodule

// File: doc/cont_ctrl.md
# cont_ctrl

Run/pause/step sequencer for the 3-bit modulo counter that drives the HEX4 seven-segment decoder. Push buttons and switches are synchronised, debounced and turned into single-cycle commands. A 3-state FSM then advances the count: automatically at a prescaled rate, or one step per button press. The block replaces direct button clocking of the counter and owns the count register; the existing decoder consumes `count`.

## Interface
- `PRESCALE`, 50_000_000: clk cycles between automatic advances in RUN (≥2).
- `DEBOUNCE_CYC`, 500_000: consecutive stable cycles required to accept a button level (≥2).
- `MOD`, 8: counter modulus (2..2^W).
- `W`, 3: count width.

- `clk` input 1: system clock, all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_run_n` input 1: run/pause button, active-low, asynchronous to clk.
- `btn_step_n` input 1: single-step button, active-low, asynchronous.
- `up_dn` input 1: direction switch; 1 = up, 0 = down; asynchronous level.
- `clr` input 1: synchronous clear request, level, already synchronous to clk.
- `count` output W: current count, feeds the decoder.
- `running` output 1: 1 while the FSM is in RUN.
- `tc` output 1: one-cycle pulse on wrap-around.

## Operation
- Input conditioning:
  - Each button and `up_dn` passes through a 2-flop synchroniser.
  - Buttons are then debounced: the accepted level changes only after `DEBOUNCE_CYC` consecutive equal samples.
  - The press command (`run_p`, `step_p`) is a one-cycle pulse on the accepted 1→0 transition. Release produces no pulse.
- FSM states and transitions:
  - IDLE: `count` held at 0. `run_p` → RUN. `step_p` → PAUSE plus one advance.
  - RUN: advance on each prescaler tick. `run_p` → PAUSE. `step_p` is ignored.
  - PAUSE: `step_p` gives one advance. `run_p` → RUN.
- `clr` has highest priority in every state: next cycle FSM = IDLE, `count` = 0, prescaler = 0, `tc` = 0.
- Advance rules:
  - Up: `count` = MOD-1 → 0 with `tc`=1; otherwise `count`+1.
  - Down: `count` = 0 → MOD-1 with `tc`=1; otherwise `count`-1.
  - All arithmetic is W bits wide; `count` never leaves 0..MOD-1.
- Direction is sampled at the advance cycle, so a change mid-interval applies to the next advance only.
- Simultaneous events:
  - `run_p` and `step_p` in the same cycle: run wins and the step is dropped.
  - A tick coinciding with `run_p` in RUN: no advance, go to PAUSE.
- Prescaler:
  - Counts 0..PRESCALE-1 only while in RUN and wraps; the tick fires on the wrap.
  - It is cleared on every entry into RUN and holds its value in PAUSE and IDLE.

## Timing
- Reset values: `count`=0, `running`=0, `tc`=0, FSM=IDLE, prescaler=0. Synchronisers reset to 1 (released); debounced levels reset to 1.
- Button-to-command latency: 2 sync cycles + `DEBOUNCE_CYC` cycles, then the `run_p`/`step_p` pulse.
- `count`, `running` and `tc` are registered and update the cycle after the command pulse or tick.
- First automatic advance: `PRESCALE` cycles after `running` rises; advances follow every `PRESCALE` cycles.
- Reset asserted mid-operation: all state returns to reset values immediately. A button held through reset release produces no press pulse until it is released and pressed again.

## Configuration
- `CONT_CTRL_AUTORUN_EN` defined: prescaler present; RUN advances on ticks as described.
- Not defined:
  - No prescaler logic.
  - RUN advances only on `step_p`, which is accepted in RUN as well as PAUSE.
  - `running` still reflects the RUN state. All other behaviour is unchanged.

## Structure
- Shared package `cont_pkg`:
  - FSM state encoding: `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_PAUSE`=2'd2.
  - Default parameter constants.
- Sub-module `cont_debounce`: synchroniser, debounce counter and press-edge pulse. Instantiated once per button.
- `up_dn` uses only the 2-flop synchroniser, no debounce.

## Test plan
All scenarios use PRESCALE=4, DEBOUNCE_CYC=3, MOD=8, with the macro defined unless noted.
- Reset then no input → `count`=0, `running`=0, `tc`=0 for 50 cycles.
- Press run (held 10 cycles), `up_dn`=1 → `running`=1; `count` steps 1,2,…,7,0 every 4 cycles; `tc` pulses exactly once at the 7→0 step.
- In RUN press run, then step twice with `up_dn`=0 from `count`=2 → PAUSE; `count` goes 1, then 0; a third step gives 7 with `tc`=1.
- Button bounce: btn_run_n toggles every cycle for 8 cycles, then held low → exactly one `run_p`, giving a single IDLE→RUN transition.
- Assert `clr` for 1 cycle at `count`=5 in RUN → next cycle `count`=0, `running`=0; a subsequent run press restarts with the first advance 4 cycles after `running` rises.
- Macro undefined: press run, wait 40 cycles → `count` stays 0; press step twice → `count`=2.
